// File: rtl/vga_pkg.sv
// Shared constants for the text-mode VGA engine: default timing, the tile-word layout,
// the CGA palette and a width helper.
package vga_pkg;

    localparam int H_ACTIVE_DEF     = 640;
    localparam int H_FP_DEF         = 16;
    localparam int H_SYNC_DEF       = 96;
    localparam int H_BP_DEF         = 48;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int V_FP_DEF         = 10;
    localparam int V_SYNC_DEF       = 2;
    localparam int V_BP_DEF         = 33;
    localparam int FONT_W_DEF       = 8;
    localparam int FONT_H_DEF       = 16;
    localparam int BLINK_FRAMES_DEF = 30;

    localparam int TILE_W        = 16;
    localparam int TILE_FG_LSB   = 12;
    localparam int TILE_BG_LSB   = 8;
    localparam int TILE_CHAR_LSB = 0;
    localparam int COLOR_W       = 4;
    localparam int CHAR_W        = 8;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // Index width for n entries, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with decoded active, sync and frame-origin flags.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic                                             clk_i,
    input  logic                                             rstn_i,
    output logic [width_of(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]   h_cnt,
    output logic [width_of(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]   v_cnt,
    output logic                                             active,
    output logic                                             hsync,
    output logic                                             vsync,
    output logic                                             frame_start
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   HW      = width_of(H_TOTAL);
    localparam int   VW      = width_of(V_TOTAL);
    localparam logic HS_ON   = (HS_POL != 0);
    localparam logic VS_ON   = (VS_POL != 0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hsync       = ((int'(h_cnt) >= H_ACTIVE + H_FP) &&
                       (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC)) ? HS_ON : ~HS_ON;
        vsync       = ((int'(v_cnt) >= V_ACTIVE + V_FP) &&
                       (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC)) ? VS_ON : ~VS_ON;
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_text_engine.sv
// Text-mode pixel engine: three-stage tile -> glyph -> palette pipeline with
// per-frame row scrolling and a blinking block cursor.
module vga_text_engine import vga_pkg::*; #(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter int HS_POL       = 0,
    parameter int VS_POL       = 0,
    parameter int FONT_W       = FONT_W_DEF,
    parameter int FONT_H       = FONT_H_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                                                          clk_i,
    input  logic                                                          rstn_i,
    input  logic [width_of(V_ACTIVE/FONT_H)-1:0]                          scroll_row_i,
    input  logic                                                          cursor_en_i,
    input  logic [width_of(H_ACTIVE/FONT_W)-1:0]                          cursor_col_i,
    input  logic [width_of(V_ACTIVE/FONT_H)-1:0]                          cursor_row_i,
    output logic [width_of((H_ACTIVE/FONT_W)*(V_ACTIVE/FONT_H))-1:0]      tile_addr_o,
    input  logic [TILE_W-1:0]                                             tile_data_i,
    output logic [CHAR_W+width_of(FONT_H)-1:0]                            font_addr_o,
    input  logic [FONT_W-1:0]                                             font_data_i,
    output logic [11:0]                                                   rgb_o,
    output logic                                                          hsync_o,
    output logic                                                          vsync_o,
    output logic                                                          de_o,
    output logic                                                          frame_start_o
);

    localparam int   N_COL  = H_ACTIVE / FONT_W;
    localparam int   N_ROW  = V_ACTIVE / FONT_H;
    localparam int   COL_W  = width_of(N_COL);
    localparam int   ROW_W  = width_of(N_ROW);
    localparam int   TA_W   = width_of(N_COL * N_ROW);
    localparam int   GR_W   = width_of(FONT_H);
    localparam int   XW     = width_of(FONT_W);
    localparam int   HW     = width_of(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int   VW     = width_of(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int   BW     = width_of(BLINK_FRAMES);
    localparam logic HS_OFF = (HS_POL == 0);
    localparam logic VS_OFF = (VS_POL == 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          t_active, t_hs, t_vs, t_fs;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL)
    ) u_timing (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (t_active),
        .hsync       (t_hs),
        .vsync       (t_vs),
        .frame_start (t_fs)
    );

    logic [ROW_W-1:0] scroll_lat, scroll_eff, crow_lat, crow_eff;
    logic [COL_W-1:0] ccol_lat, ccol_eff;
    logic             cen_lat, cen_eff, blink_lat, phase_eff, blink_phase;
    logic [BW-1:0]    blink_cnt;
    logic [TA_W-1:0]  addr_nxt;
    logic             swap_nxt;
    int               col, row, brow;

    // The origin pixel itself must already see the newly sampled settings,
    // so the frame settings are bypassed from the inputs at (0,0).
    always_comb begin
        scroll_eff = scroll_lat;
        cen_eff    = cen_lat;
        ccol_eff   = ccol_lat;
        crow_eff   = crow_lat;
        phase_eff  = blink_lat;
        if (t_fs) begin
            if (int'(scroll_row_i) < N_ROW) scroll_eff = scroll_row_i;
            cen_eff   = cursor_en_i;
            ccol_eff  = cursor_col_i;
            crow_eff  = cursor_row_i;
            phase_eff = blink_phase;
        end
        col      = int'(h_cnt) / FONT_W;
        row      = int'(v_cnt) / FONT_H;
        brow     = (row + int'(scroll_eff)) % N_ROW;
        addr_nxt = t_active ? TA_W'(brow * N_COL + col) : '0;
        swap_nxt = t_active && cen_eff && phase_eff &&
                   (col == int'(ccol_eff)) && (row == int'(crow_eff));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scroll_lat  <= '0;
            cen_lat     <= 1'b0;
            ccol_lat    <= '0;
            crow_lat    <= '0;
            blink_lat   <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (t_fs) begin
            scroll_lat <= scroll_eff;
            cen_lat    <= cen_eff;
            ccol_lat   <= ccol_eff;
            crow_lat   <= crow_eff;
            blink_lat  <= blink_phase;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic [XW-1:0]      s1_x, s2_x;
    logic [GR_W-1:0]    s1_gr;
    logic [COLOR_W-1:0] s2_fg, s2_bg;
    logic               s1_swap, s1_de, s1_hs, s1_vs, s1_fs;
    logic               s2_swap, s2_de, s2_hs, s2_vs, s2_fs;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tile_addr_o <= '0;
            s1_x        <= '0;
            s1_gr       <= '0;
            s1_swap     <= 1'b0;
            s1_de       <= 1'b0;
            s1_hs       <= HS_OFF;
            s1_vs       <= VS_OFF;
            s1_fs       <= 1'b0;
            font_addr_o <= '0;
            s2_x        <= '0;
            s2_fg       <= '0;
            s2_bg       <= '0;
            s2_swap     <= 1'b0;
            s2_de       <= 1'b0;
            s2_hs       <= HS_OFF;
            s2_vs       <= VS_OFF;
            s2_fs       <= 1'b0;
        end else begin
            tile_addr_o <= addr_nxt;
            s1_x        <= XW'(int'(h_cnt) % FONT_W);
            s1_gr       <= GR_W'(int'(v_cnt) % FONT_H);
            s1_swap     <= swap_nxt;
            s1_de       <= t_active;
            s1_hs       <= t_hs;
            s1_vs       <= t_vs;
            s1_fs       <= t_fs;
            font_addr_o <= {tile_data_i[TILE_CHAR_LSB +: CHAR_W], s1_gr};
            s2_x        <= s1_x;
            s2_fg       <= tile_data_i[TILE_FG_LSB +: COLOR_W];
            s2_bg       <= tile_data_i[TILE_BG_LSB +: COLOR_W];
            s2_swap     <= s1_swap;
            s2_de       <= s1_de;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_fs       <= s1_fs;
        end
    end

    logic               pix;
    logic [COLOR_W-1:0] idx;

    always_comb begin
        pix = font_data_i[XW'(FONT_W - 1) - s2_x];
        if (pix ^ s2_swap) idx = s2_fg;
        else               idx = s2_bg;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rgb_o         <= '0;
            de_o          <= 1'b0;
            hsync_o       <= HS_OFF;
            vsync_o       <= VS_OFF;
            frame_start_o <= 1'b0;
        end else begin
            rgb_o         <= s2_de ? PALETTE[idx] : '0;
            de_o          <= s2_de;
            hsync_o       <= s2_hs;
            vsync_o       <= s2_vs;
            frame_start_o <= s2_fs;
        end
    end

endmodule

// File: tb/tb_vga_text_engine.sv
// Randomised bench for vga_text_engine on a small raster, checked against a
// cycle-index arithmetic model of the visible frame.
module tb_vga_text_engine;

    localparam int HA = 40, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
    localparam int VA = 24, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;
    localparam int FW = 8, FH = 8, BF = 2;
    localparam int NC = HA / FW, NR = VA / FH, FT = HT * VT;

    typedef struct {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  scroll_row = '0;
    logic        cursor_en = 1'b0;
    logic [2:0]  cursor_col = '0;
    logic [1:0]  cursor_row = '0;
    logic [3:0]  tile_addr;
    logic [15:0] tile_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;
    logic        hsync, vsync, de, frame_start;

    logic [15:0] tile_mem [16];
    logic [7:0]  font_mem [2048];
    logic [11:0] pal [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    int   fr_scroll [64];
    logic fr_cen    [64];
    int   fr_ccol   [64];
    int   fr_crow   [64];
    int   m_scroll = 0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    assign tile_data = tile_mem[tile_addr];
    assign font_data = font_mem[font_addr];

    vga_text_engine #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (0), .VS_POL (0), .FONT_W (FW), .FONT_H (FH), .BLINK_FRAMES (BF)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .scroll_row_i  (scroll_row),
        .cursor_en_i   (cursor_en),
        .cursor_col_i  (cursor_col),
        .cursor_row_i  (cursor_row),
        .tile_addr_o   (tile_addr),
        .tile_data_i   (tile_data),
        .font_addr_o   (font_addr),
        .font_data_i   (font_data),
        .rgb_o         (rgb),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .de_o          (de),
        .frame_start_o (frame_start)
    );

    // Expected pins after k clock edges since reset release (pins lag the raster by 3).
    function automatic exp_t model(int k);
        exp_t        e;
        int          q, h, v, f, col, row, br, fg, bg;
        logic [15:0] t;
        logic [7:0]  gl;
        logic        b;
        e.rgb = '0; e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
        if (k < 3) return e;
        q = k - 3;
        h = q % HT;
        v = (q / HT) % VT;
        f = q / FT;
        e.de = (h < HA) && (v < VA);
        e.hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        e.vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        e.fs = (h == 0) && (v == 0);
        if (e.de) begin
            col = h / FW;
            row = v / FH;
            br  = (row + fr_scroll[f]) % NR;
            t   = tile_mem[4'(br * NC + col)];
            gl  = font_mem[11'(int'(t[7:0]) * FH + v % FH)];
            b   = gl[3'(FW - 1 - h % FW)];
            fg  = int'(t[15:12]);
            bg  = int'(t[11:8]);
            if (fr_cen[f] && col == fr_ccol[f] && row == fr_crow[f] && ((f / BF) % 2 == 1))
                b = ~b;
            e.rgb = pal[b ? fg : bg];
        end
        return e;
    endfunction

    // Expected tile address after k edges: it reflects the raster position one cycle back.
    function automatic int exp_taddr(int k);
        int p, h, v, f;
        if (k < 1) return 0;
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FT;
        if (h < HA && v < VA) return ((v / FH + fr_scroll[f]) % NR) * NC + h / FW;
        return 0;
    endfunction

    task automatic step();
        if (cyc % FT == 0 && cyc / FT < 64) begin
            if (int'(scroll_row) < NR) m_scroll = int'(scroll_row);
            fr_scroll[cyc / FT] = m_scroll;
            fr_cen[cyc / FT]    = cursor_en;
            fr_ccol[cyc / FT]   = int'(cursor_col);
            fr_crow[cyc / FT]   = int'(cursor_row);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_scroll = 0;
        cyc = 0;
        rstn = 1'b1;
    endtask

    task automatic fill_mem();
        int fg;
        for (int i = 0; i < 16; i++) begin
            fg = int'($urandom_range(15, 0));
            tile_mem[i] = {4'(fg), 4'((fg + int'($urandom_range(15, 1))) % 16), 8'($urandom)};
        end
        tile_mem[0] = 16'hF041;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        #3 rstn = 1'b0;
        #1;
        nchk++; if (rgb !== 12'h000) begin nerr++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        nchk++; if (de !== 1'b0) begin nerr++; $display("FAIL reset_de got %b exp 0", de); end
        nchk++; if (hsync !== 1'b1) begin nerr++; $display("FAIL reset_hsync got %b exp 1", hsync); end
        nchk++; if (vsync !== 1'b1) begin nerr++; $display("FAIL reset_vsync got %b exp 1", vsync); end
        nchk++; if (frame_start !== 1'b0) begin nerr++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        nchk++; if (tile_addr !== 4'd0) begin nerr++; $display("FAIL reset_taddr got %0d exp 0", tile_addr); end
        nchk++; if (font_addr !== 11'd0) begin nerr++; $display("FAIL reset_faddr got %0d exp 0", font_addr); end
        @(negedge clk);
        m_scroll = 0;
        cyc = 0;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            nchk++;
            if (frame_start !== (cyc == 3)) begin
                nerr++; $display("FAIL first_fs edge=%0d got %b exp %b", cyc, frame_start, cyc == 3);
            end
        end
    endtask

    task automatic test_sync_timing();
        exp_t e;
        int hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0;
        scroll_row = 2'd0; cursor_en = 1'b0;
        do_reset();
        for (int i = 0; i < FT + 2; i++) begin
            step();
            if (cyc >= 3) begin
                e = model(cyc);
                hs_low += (hsync == 1'b0) ? 1 : 0;
                vs_low += (vsync == 1'b0) ? 1 : 0;
                de_cnt += (de == 1'b1) ? 1 : 0;
                fs_cnt += (frame_start == 1'b1) ? 1 : 0;
                nchk++; if (hsync !== e.hs) begin nerr++; $display("FAIL hsync k=%0d got %b exp %b", cyc, hsync, e.hs); end
                nchk++; if (vsync !== e.vs) begin nerr++; $display("FAIL vsync k=%0d got %b exp %b", cyc, vsync, e.vs); end
                nchk++; if (de !== e.de) begin nerr++; $display("FAIL de k=%0d got %b exp %b", cyc, de, e.de); end
                nchk++; if (frame_start !== e.fs) begin nerr++; $display("FAIL fs k=%0d got %b exp %b", cyc, frame_start, e.fs); end
            end
        end
        nchk++; if (hs_low != HSW * VT) begin nerr++; $display("FAIL hs_low_count got %0d exp %0d", hs_low, HSW * VT); end
        nchk++; if (vs_low != VSW * HT) begin nerr++; $display("FAIL vs_low_count got %0d exp %0d", vs_low, VSW * HT); end
        nchk++; if (de_cnt != HA * VA) begin nerr++; $display("FAIL de_count got %0d exp %0d", de_cnt, HA * VA); end
        nchk++; if (fs_cnt != 1) begin nerr++; $display("FAIL fs_count got %0d exp 1", fs_cnt); end
    endtask

    task automatic test_glyph_pixels();
        exp_t e;
        scroll_row = 2'd0; cursor_en = 1'b0;
        do_reset();
        for (int i = 0; i < FT + 3; i++) begin
            step();
            e = model(cyc);
            nchk++; if (rgb !== e.rgb) begin nerr++; $display("FAIL glyph_rgb k=%0d got %h exp %h", cyc, rgb, e.rgb); end
        end
    endtask

    task automatic test_scroll_midframe();
        exp_t e;
        scroll_row = 2'd0; cursor_en = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * FT + 3; i++) begin
            step();
            if (cyc == FT / 2) scroll_row = 2'd1;
            e = model(cyc);
            nchk++; if (rgb !== e.rgb) begin nerr++; $display("FAIL scroll_rgb k=%0d got %h exp %h", cyc, rgb, e.rgb); end
            nchk++;
            if (tile_addr !== 4'(exp_taddr(cyc))) begin
                nerr++; $display("FAIL scroll_taddr k=%0d got %0d exp %0d", cyc, tile_addr, exp_taddr(cyc));
            end
        end
    endtask

    task automatic test_scroll_out_of_range();
        exp_t e;
        scroll_row = 2'd0; cursor_en = 1'b0;
        do_reset();
        for (int i = 0; i < 3 * FT + 3; i++) begin
            step();
            if (cyc == FT / 2) scroll_row = 2'd2;
            if (cyc == FT + FT / 2) scroll_row = 2'd3;
            e = model(cyc);
            nchk++; if (rgb !== e.rgb) begin nerr++; $display("FAIL range_rgb k=%0d got %h exp %h", cyc, rgb, e.rgb); end
            nchk++;
            if (tile_addr !== 4'(exp_taddr(cyc))) begin
                nerr++; $display("FAIL range_taddr k=%0d got %0d exp %0d", cyc, tile_addr, exp_taddr(cyc));
            end
        end
    endtask

    task automatic test_cursor_blink();
        exp_t e;
        scroll_row = 2'd0;
        cursor_en  = 1'b1;
        cursor_col = 3'(NC - 1);
        cursor_row = 2'(NR - 1);
        do_reset();
        for (int i = 0; i < 6 * FT + 3; i++) begin
            step();
            e = model(cyc);
            nchk++; if (rgb !== e.rgb) begin nerr++; $display("FAIL cursor_rgb k=%0d got %h exp %h", cyc, rgb, e.rgb); end
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        scroll_row = 2'd1; cursor_en = 1'b0;
        do_reset();
        while (cyc < 20 * HT + 30) step();
        #2 rstn = 1'b0;
        #1;
        nchk++; if (rgb !== 12'h000) begin nerr++; $display("FAIL mid_rgb got %h exp 000", rgb); end
        nchk++; if (de !== 1'b0) begin nerr++; $display("FAIL mid_de got %b exp 0", de); end
        nchk++; if (hsync !== 1'b1) begin nerr++; $display("FAIL mid_hsync got %b exp 1", hsync); end
        nchk++; if (vsync !== 1'b1) begin nerr++; $display("FAIL mid_vsync got %b exp 1", vsync); end
        nchk++; if (frame_start !== 1'b0) begin nerr++; $display("FAIL mid_fs got %b exp 0", frame_start); end
        nchk++; if (tile_addr !== 4'd0) begin nerr++; $display("FAIL mid_taddr got %0d exp 0", tile_addr); end
        nchk++; if (font_addr !== 11'd0) begin nerr++; $display("FAIL mid_faddr got %0d exp 0", font_addr); end
        @(negedge clk);
        @(negedge clk);
        m_scroll = 0;
        cyc = 0;
        rstn = 1'b1;
        for (int i = 0; i < FT + 3; i++) begin
            step();
            e = model(cyc);
            nchk++; if (frame_start !== e.fs) begin nerr++; $display("FAIL post_fs k=%0d got %b exp %b", cyc, frame_start, e.fs); end
            nchk++; if (de !== e.de) begin nerr++; $display("FAIL post_de k=%0d got %b exp %b", cyc, de, e.de); end
            nchk++; if (rgb !== e.rgb) begin nerr++; $display("FAIL post_rgb k=%0d got %h exp %h", cyc, rgb, e.rgb); end
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_sync_timing();
        test_glyph_pixels();
        test_scroll_midframe();
        test_scroll_out_of_range();
        test_cursor_blink();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
